// File: rtl/pll_clken_bank.sv
// pll_clken_bank: NUM_CH fractional clock enables from one PLL clock, plus debounced lock-to-ready sequencing.
// Optional feature macro: PLL_CLKEN_ALIGN_EN (align_req restarts all phase accumulators in phase).
module pll_clken_bank #(
    parameter int                      NUM_CH      = 4,
    parameter int                      ACC_W       = 24,
    parameter int                      LOCK_STABLE = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              align_req,
    output logic [NUM_CH-1:0] clken,
    output logic              ready,
    output logic              locked_sync
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(LOCK_STABLE);
    // The WAIT_LOCK exit edge already counts as one stable cycle, so STABLE stops one short.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 2);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               ready_q, ready_d;
    logic [NUM_CH-1:0]  clken_q, clken_d;
    logic [ACC_W-1:0]   acc_q [NUM_CH];
    logic [ACC_W-1:0]   acc_d [NUM_CH];
    logic [ACC_W-1:0]   inc_q [NUM_CH];
    logic [ACC_W-1:0]   inc_d [NUM_CH];
    logic [ACC_W:0]     sum_s [NUM_CH];
    logic               run_s;
    logic               align_s;

`ifdef PLL_CLKEN_ALIGN_EN
    assign align_s = align_req;
`else
    logic align_unused_s;
    assign align_s        = 1'b0;
    assign align_unused_s = align_req;
`endif

    // Lock synchroniser and lock-debounce sequencer next state.
    always_comb begin
        sync1_d = pll_locked;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = STABLE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = STABLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == RUN);
    end

    // Per-channel phase accumulators and increment register writes.
    always_comb begin
        run_s   = (state_q == RUN) && sync2_q;
        clken_d = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            sum_s[n] = {1'b0, acc_q[n]} + {1'b0, inc_q[n]};
            // Lock loss (or leaving RUN) wins over align and accumulate: everything clears.
            if (!run_s || align_s) begin
                acc_d[n]   = '0;
                clken_d[n] = 1'b0;
            end else if (ch_en[n]) begin
                acc_d[n]   = sum_s[n][ACC_W-1:0];
                clken_d[n] = sum_s[n][ACC_W];
            end else begin
                acc_d[n]   = acc_q[n];
                clken_d[n] = 1'b0;
            end
            if (cfg_wr && (cfg_ch == 4'(n))) begin
                inc_d[n] = cfg_inc;
            end else begin
                inc_d[n] = inc_q[n];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            clken_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                acc_q[n] <= '0;
                inc_q[n] <= INC_INIT[n*ACC_W +: ACC_W];
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            clken_q <= clken_d;
            for (int n = 0; n < NUM_CH; n++) begin
                acc_q[n] <= acc_d[n];
                inc_q[n] <= inc_d[n];
            end
        end
    end

    assign clken       = clken_q;
    assign ready       = ready_q;
    assign locked_sync = sync2_q;

endmodule

// File: tb/tb_pll_clken_bank.sv
// tb_pll_clken_bank: randomized self-checking bench for pll_clken_bank against a behavioural reference model.
// Honours PLL_CLKEN_ALIGN_EN to select the expected align_req behaviour.
module tb_pll_clken_bank;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 24;
    localparam int LS     = 16;
    localparam logic [NUM_CH*ACC_W-1:0] INC_INIT = {24'h400000, 24'h000000, 24'h000000, 24'h000000};
`ifdef PLL_CLKEN_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam longint MOD = 64'd1 << ACC_W;

    logic              refclk = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic              cfg_wr;
    logic [3:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] ch_en;
    logic              align_req;
    logic [NUM_CH-1:0] clken;
    logic              ready;
    logic              locked_sync;

    pll_clken_bank #(
        .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_STABLE(LS), .INC_INIT(INC_INIT)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_wr(cfg_wr),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .ch_en(ch_en), .align_req(align_req),
        .clken(clken), .ready(ready), .locked_sync(locked_sync)
    );

    always #5 refclk = ~refclk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int pc [NUM_CH];

    // Reference model: phases as plain integers, ready as a run-length of stable lock samples.
    longint            m_ph  [NUM_CH];
    longint            m_inc [NUM_CH];
    logic [NUM_CH-1:0] m_clken;
    logic              m_ready;
    logic              m_ls;
    logic              m_p1;
    int                m_hi;
    logic [NUM_CH*ACC_W-1:0] init_v = INC_INIT;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        logic   run;
        longint t;
        if (rst) begin
            for (int n = 0; n < NUM_CH; n++) begin
                m_ph[n]  = 0;
                m_inc[n] = longint'(init_v[n*ACC_W +: ACC_W]);
            end
            m_clken = '0;
            m_ready = 1'b0;
            m_ls    = 1'b0;
            m_p1    = 1'b0;
            m_hi    = 0;
        end else begin
            run = m_ready && m_ls;
            for (int n = 0; n < NUM_CH; n++) begin
                if (!run || (ALIGN_EN && align_req)) begin
                    m_ph[n]    = 0;
                    m_clken[n] = 1'b0;
                end else if (ch_en[n]) begin
                    t          = m_ph[n] + m_inc[n];
                    m_clken[n] = (t >= MOD);
                    m_ph[n]    = t % MOD;
                end else begin
                    m_clken[n] = 1'b0;
                end
            end
            if (cfg_wr && (cfg_ch < NUM_CH)) m_inc[cfg_ch] = longint'(cfg_inc);
            // Ready needs LS consecutive synchronised-high samples; any low sample restarts it.
            m_hi    = m_ls ? ((m_hi < LS) ? m_hi + 1 : m_hi) : 0;
            m_ready = (m_hi >= LS);
            m_ls    = m_p1;
            m_p1    = pll_locked;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge refclk);
        #1;
        edge_n++;
        check("clken", 64'(clken), 64'(m_clken));
        check("ready", 64'(ready), 64'(m_ready));
        check("locked_sync", 64'(locked_sync), 64'(m_ls));
        for (int n = 0; n < NUM_CH; n++) if (clken[n] === 1'b1) pc[n]++;
    endtask

    task automatic clear_pc();
        for (int n = 0; n < NUM_CH; n++) pc[n] = 0;
    endtask

    task automatic wait_ready(input string name, input int k);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        check(name, 64'(edge_n), 64'(k + LS + 1));
    endtask

    initial begin
        int c0, last0, bad_gap, dbl, j, k, mism;
        logic prev;
        logic [ACC_W-1:0] r;

        rst = 1'b1; pll_locked = 1'b0; cfg_wr = 1'b0; cfg_ch = 4'd0;
        cfg_inc = '0; ch_en = '1; align_req = 1'b0;
        clear_pc();
        repeat (3) tick();
        check("rst_clken", 64'(clken), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_locked_sync", 64'(locked_sync), 64'd0);

        // Lock timing: pll_locked sampled high at edge 10 -> ready after edge 27.
        rst = 1'b0; edge_n = 0;
        cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_inc = 24'h19999A; tick();
        cfg_ch = 4'd1; cfg_inc = 24'h6AAAAB; tick();
        cfg_ch = 4'd2; cfg_inc = 24'h000000; tick();
        cfg_wr = 1'b0;
        while (edge_n < 9) tick();
        pll_locked = 1'b1;
        tick();
        while (edge_n < 26) tick();
        check("ready_before_27", 64'(ready), 64'd0);
        check("clken_before_27", 64'(clken), 64'd0);
        tick();
        check("ready_at_27", 64'(ready), 64'd1);

        // Rate checks over fixed windows.
        clear_pc(); c0 = 0; last0 = -1; bad_gap = 0;
        for (int i = 1; i <= 1200; i++) begin
            tick();
            if (clken[0] === 1'b1) begin
                if (last0 >= 0 && (edge_n - last0) != 9 && (edge_n - last0) != 10) bad_gap++;
                last0 = edge_n;
            end
            if (i == 1000) c0 = pc[0];
        end
        check("ch0_pulses_1000", 64'(c0), 64'd100);
        check("ch1_pulses_1200", 64'(pc[1]), 64'd500);
        check("ch2_pulses_zero", 64'(pc[2]), 64'd0);
        check("ch0_spacing", 64'(bad_gap), 64'd0);

        // Mid-run increment change to half rate: no double pulse.
        cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_inc = 24'h800000; tick();
        cfg_wr = 1'b0; clear_pc(); dbl = 0; prev = clken[0];
        repeat (20) begin
            tick();
            if (clken[0] === 1'b1 && prev === 1'b1) dbl++;
            prev = clken[0];
        end
        check("half_rate_pulses", 64'(pc[0]), 64'd10);
        check("half_rate_no_double", 64'(dbl), 64'd0);

        cfg_wr = 1'b1; cfg_ch = 4'd7; cfg_inc = 24'h000001; tick();
        cfg_wr = 1'b0; clear_pc();
        repeat (20) tick();
        check("bad_ch_ignored", 64'(pc[0]), 64'd10);

        // One-cycle lock drop in RUN.
        pll_locked = 1'b0; tick(); j = edge_n; pll_locked = 1'b1;
        tick();
        check("drop_ready_j1", 64'(ready), 64'd1);
        tick();
        check("drop_ready_j2", 64'(ready), 64'd0);
        check("drop_clken_j2", 64'(clken), 64'd0);
        wait_ready("relock_full_count", j + 1);

        // Drop seen by the sequencer while STABLE at cnt=8.
        pll_locked = 1'b0; tick(); pll_locked = 1'b1; tick(); k = edge_n;
        while (edge_n < k + 8) tick();
        pll_locked = 1'b0; tick(); pll_locked = 1'b1; tick();
        wait_ready("stable_restart", edge_n);

        // Align: equal increments written at different times, then align_req.
        r = 24'($urandom_range(32'h100000, 32'hFFFFFF));
        ch_en = '1;
        cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_inc = r; tick();
        cfg_wr = 1'b0; repeat (5) tick();
        cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_inc = r; tick();
        cfg_wr = 1'b0; repeat (3) tick();
        align_req = 1'b1; tick(); align_req = 1'b0;
`ifdef PLL_CLKEN_ALIGN_EN
        check("align_clken_zero", 64'(clken), 64'd0);
`endif
        mism = 0;
        repeat (100) begin
            tick();
            if (clken[0] !== clken[1]) mism++;
        end
`ifdef PLL_CLKEN_ALIGN_EN
        check("align_in_phase", 64'(mism), 64'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cfg_wr    = ($urandom_range(0, 7) == 0);
            cfg_ch    = 4'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       cfg_inc = 24'h000000;
                1:       cfg_inc = 24'hFFFFFF;
                default: cfg_inc = 24'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
            align_req  = ($urandom_range(0, 31) == 0);
            pll_locked = ($urandom_range(0, 599) != 0);
            tick();
        end

        // Reset mid-operation restores INC_INIT.
        cfg_wr = 1'b0; align_req = 1'b0; ch_en = '1; pll_locked = 1'b1;
        rst = 1'b1; tick(); tick();
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_clken", 64'(clken), 64'd0);
        rst = 1'b0;
        wait_ready("rst_relock", edge_n + 1);
        clear_pc();
        repeat (40) tick();
        check("init_inc_ch3", 64'(pc[3]), 64'd10);
        check("init_inc_ch0", 64'(pc[0]), 64'd0);
        check("init_inc_ch1", 64'(pc[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
